// File: rtl/top_pkg.sv
// top_pkg
// Shared constants for the 32-point DFT: frame length, twiddle format,
// accumulator sizing, the frame-phase enum and the cos/sin twiddle tables.
// No ports (package).
package top_pkg;

    localparam int FRAME_LEN = 32;
    localparam int IDX_W     = 5;
    localparam int TW_W      = 16;
    localparam int TW_FRAC   = 14;
    localparam int ACC_GUARD = 6;

    // Accumulator width for an N-bit sample: full product plus log2(32)
    // growth plus one spare bit, so the sum of 32 products never wraps.
    function automatic int accWidth(input int n);
        return n + TW_W + ACC_GUARD;
    endfunction

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_ACC  = 1'b1
    } frame_state_t;

    // round(16384 * cos(2*pi*m/32)), m = 0..31
    localparam logic signed [TW_W-1:0] COS_TABLE [FRAME_LEN] = '{
         16'sd16384,  16'sd16069,  16'sd15137,  16'sd13623,
         16'sd11585,  16'sd9102,   16'sd6270,   16'sd3196,
         16'sd0,     -16'sd3196,  -16'sd6270,  -16'sd9102,
        -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069,
        -16'sd16384, -16'sd16069, -16'sd15137, -16'sd13623,
        -16'sd11585, -16'sd9102,  -16'sd6270,  -16'sd3196,
         16'sd0,      16'sd3196,   16'sd6270,   16'sd9102,
         16'sd11585,  16'sd13623,  16'sd15137,  16'sd16069
    };

    // round(16384 * sin(2*pi*m/32)), m = 0..31
    localparam logic signed [TW_W-1:0] SIN_TABLE [FRAME_LEN] = '{
         16'sd0,      16'sd3196,   16'sd6270,   16'sd9102,
         16'sd11585,  16'sd13623,  16'sd15137,  16'sd16069,
         16'sd16384,  16'sd16069,  16'sd15137,  16'sd13623,
         16'sd11585,  16'sd9102,   16'sd6270,   16'sd3196,
         16'sd0,     -16'sd3196,  -16'sd6270,  -16'sd9102,
        -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069,
        -16'sd16384, -16'sd16069, -16'sd15137, -16'sd13623,
        -16'sd11585, -16'sd9102,  -16'sd6270,  -16'sd3196
    };

endpackage

// File: rtl/top_dft_bin.sv
// dft_bin
// One DFT bin: complex multiply-accumulate of the real sample stream against
// the bin's twiddle sequence, then round-half-up and saturate into N bits.
// Ports:
//   i_clk, i_rst     clock, async active-high reset
//   i_load           clear the accumulators (frame start)
//   i_acc            add this cycle's product term
//   i_last           this is the final term; register the rounded result
//   i_sample         current snapshot sample x[n]
//   i_sampleIdx      n, used to pick twiddle (K*n) mod 32
//   o_re, o_im       registered bin result, held for the whole frame
module dft_bin
    import top_pkg::*;
#(
    parameter int N = 16,
    parameter int K = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic                 i_acc,
    input  logic                 i_last,
    input  logic signed [N-1:0]  i_sample,
    input  logic [IDX_W-1:0]     i_sampleIdx,
    output logic signed [N-1:0]  o_re,
    output logic signed [N-1:0]  o_im
);

    localparam int ACC_W  = accWidth(N);
    localparam int PROD_W = N + TW_W;
    localparam logic [IDX_W-1:0] BIN_IDX = IDX_W'(K);
    localparam logic signed [ACC_W-1:0] RND_CONST = ACC_W'(1) << (TW_FRAC - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

    logic [IDX_W-1:0]         w_twIdx;
    logic signed [TW_W-1:0]   w_cos;
    logic signed [TW_W-1:0]   w_sin;
    logic signed [PROD_W-1:0] w_sampleExt;
    logic signed [PROD_W-1:0] w_cosExt;
    logic signed [PROD_W-1:0] w_sinExt;
    logic signed [PROD_W-1:0] w_prodRe;
    logic signed [PROD_W-1:0] w_prodIm;
    logic signed [ACC_W-1:0]  r_accRe;
    logic signed [ACC_W-1:0]  r_accIm;
    logic signed [ACC_W-1:0]  w_accReNext;
    logic signed [ACC_W-1:0]  w_accImNext;
    logic signed [ACC_W-1:0]  w_shiftRe;
    logic signed [ACC_W-1:0]  w_shiftIm;

    // Clamp a rounded accumulator value into the signed N-bit output range.
    function automatic logic signed [N-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[N-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[N-1:0];
        end
        return v[N-1:0];
    endfunction

    // The twiddle index wraps naturally because the product is kept to 5 bits.
    assign w_twIdx     = BIN_IDX * i_sampleIdx;
    assign w_cos       = COS_TABLE[w_twIdx];
    assign w_sin       = SIN_TABLE[w_twIdx];
    assign w_sampleExt = {{TW_W{i_sample[N-1]}}, i_sample};
    assign w_cosExt    = {{N{w_cos[TW_W-1]}}, w_cos};
    assign w_sinExt    = {{N{w_sin[TW_W-1]}}, w_sin};
    assign w_prodRe    = w_sampleExt * w_cosExt;
    assign w_prodIm    = w_sampleExt * w_sinExt;

    // The imaginary part subtracts because the DFT kernel is cos - j*sin.
    assign w_accReNext = r_accRe + {{ACC_GUARD{w_prodRe[PROD_W-1]}}, w_prodRe};
    assign w_accImNext = r_accIm - {{ACC_GUARD{w_prodIm[PROD_W-1]}}, w_prodIm};

    // Rounding is taken from the next-state sum so the last term is included
    // on the same edge that publishes the result.
    assign w_shiftRe = (w_accReNext + RND_CONST) >>> TW_FRAC;
    assign w_shiftIm = (w_accImNext + RND_CONST) >>> TW_FRAC;

    // Accumulators clear at frame start and integrate one term per ACC cycle;
    // the outputs only change on the final term so they never expose a
    // partial sum, and reset wipes everything immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_accRe <= '0;
            r_accIm <= '0;
            o_re    <= '0;
            o_im    <= '0;
        end else if (i_load) begin
            r_accRe <= '0;
            r_accIm <= '0;
        end else if (i_acc) begin
            r_accRe <= w_accReNext;
            r_accIm <= w_accImNext;
            if (i_last) begin
                o_re <= saturate(w_shiftRe);
                o_im <= saturate(w_shiftIm);
            end
        end
    end

endmodule

// File: rtl/top.sv
// top
// Free-running 32-point real-input DFT with a 33-cycle frame:
// LOAD snapshots the inputs, ACC0..ACC31 accumulate all bins in parallel,
// and the results update on the edge that ends ACC31.
// Ports:
//   clk2             single clock, rising edge
//   rst              async active-high reset
//   in<k>_r          real sample x[k], k = 0..31
//   out<k>_r/_i      real / imaginary part of bin X[k], k = 0..31
module top
    import top_pkg::*;
#(
    parameter int N = 16,
    parameter int Q = 0
) (
    input  logic clk2,
    input  logic rst,
    input  logic signed [N-1:0] in0_r,  in1_r,  in2_r,  in3_r,  in4_r,  in5_r,  in6_r,  in7_r,
                                in8_r,  in9_r,  in10_r, in11_r, in12_r, in13_r, in14_r, in15_r,
                                in16_r, in17_r, in18_r, in19_r, in20_r, in21_r, in22_r, in23_r,
                                in24_r, in25_r, in26_r, in27_r, in28_r, in29_r, in30_r, in31_r,
    output logic signed [N-1:0] out0_r,  out0_i,  out1_r,  out1_i,  out2_r,  out2_i,  out3_r,  out3_i,
                                out4_r,  out4_i,  out5_r,  out5_i,  out6_r,  out6_i,  out7_r,  out7_i,
                                out8_r,  out8_i,  out9_r,  out9_i,  out10_r, out10_i, out11_r, out11_i,
                                out12_r, out12_i, out13_r, out13_i, out14_r, out14_i, out15_r, out15_i,
                                out16_r, out16_i, out17_r, out17_i, out18_r, out18_i, out19_r, out19_i,
                                out20_r, out20_i, out21_r, out21_i, out22_r, out22_i, out23_r, out23_i,
                                out24_r, out24_i, out25_r, out25_i, out26_r, out26_i, out27_r, out27_i,
                                out28_r, out28_i, out29_r, out29_i, out30_r, out30_i, out31_r, out31_i
);

    logic signed [N-1:0] w_in    [FRAME_LEN];
    logic signed [N-1:0] r_snap  [FRAME_LEN];
    logic signed [N-1:0] w_binRe [FRAME_LEN];
    logic signed [N-1:0] w_binIm [FRAME_LEN];
    logic signed [N-1:0] w_curSample;
    frame_state_t        r_state;
    frame_state_t        w_nextState;
    logic [IDX_W-1:0]    r_accIdx;
    logic [IDX_W-1:0]    w_nextIdx;
    logic                w_load;
    logic                w_acc;
    logic                w_last;

    // Input and output share the same fixed-point scaling (the twiddles carry
    // all the fractional weight), so Q never enters the arithmetic; only an
    // out-of-range value is meaningless.
    if (Q < 0 || Q >= N) begin : g_fracOutOfRange
    end

    assign w_in[0]  = in0_r;  assign w_in[1]  = in1_r;  assign w_in[2]  = in2_r;  assign w_in[3]  = in3_r;
    assign w_in[4]  = in4_r;  assign w_in[5]  = in5_r;  assign w_in[6]  = in6_r;  assign w_in[7]  = in7_r;
    assign w_in[8]  = in8_r;  assign w_in[9]  = in9_r;  assign w_in[10] = in10_r; assign w_in[11] = in11_r;
    assign w_in[12] = in12_r; assign w_in[13] = in13_r; assign w_in[14] = in14_r; assign w_in[15] = in15_r;
    assign w_in[16] = in16_r; assign w_in[17] = in17_r; assign w_in[18] = in18_r; assign w_in[19] = in19_r;
    assign w_in[20] = in20_r; assign w_in[21] = in21_r; assign w_in[22] = in22_r; assign w_in[23] = in23_r;
    assign w_in[24] = in24_r; assign w_in[25] = in25_r; assign w_in[26] = in26_r; assign w_in[27] = in27_r;
    assign w_in[28] = in28_r; assign w_in[29] = in29_r; assign w_in[30] = in30_r; assign w_in[31] = in31_r;

    // Frame phase register: reset parks the counter in LOAD so the first
    // edge after release starts a clean frame.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            r_state  <= ST_LOAD;
            r_accIdx <= '0;
        end else begin
            r_state  <= w_nextState;
            r_accIdx <= w_nextIdx;
        end
    end

    // Next-phase logic: one LOAD cycle followed by 32 ACC cycles, forever.
    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_accIdx;
        w_load      = 1'b0;
        w_acc       = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_load      = 1'b1;
                w_nextState = ST_ACC;
                w_nextIdx   = '0;
            end
            ST_ACC: begin
                w_acc = 1'b1;
                if (r_accIdx == IDX_W'(FRAME_LEN - 1)) begin
                    w_last      = 1'b1;
                    w_nextState = ST_LOAD;
                    w_nextIdx   = '0;
                end else begin
                    w_nextIdx = r_accIdx + 1'b1;
                end
            end
            default: begin
                w_nextState = ST_LOAD;
                w_nextIdx   = '0;
            end
        endcase
    end

    // Snapshot: inputs are frozen at LOAD so later input changes only
    // influence the following frame.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_load) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                r_snap[i] <= w_in[i];
            end
        end
    end

    assign w_curSample = r_snap[r_accIdx];

    for (genvar k = 0; k < FRAME_LEN; k++) begin : g_bin
        dft_bin #(
            .N(N),
            .K(k)
        ) u_bin (
            .i_clk       (clk2),
            .i_rst       (rst),
            .i_load      (w_load),
            .i_acc       (w_acc),
            .i_last      (w_last),
            .i_sample    (w_curSample),
            .i_sampleIdx (r_accIdx),
            .o_re        (w_binRe[k]),
            .o_im        (w_binIm[k])
        );
    end

    assign out0_r  = w_binRe[0];  assign out0_i  = w_binIm[0];  assign out1_r  = w_binRe[1];  assign out1_i  = w_binIm[1];
    assign out2_r  = w_binRe[2];  assign out2_i  = w_binIm[2];  assign out3_r  = w_binRe[3];  assign out3_i  = w_binIm[3];
    assign out4_r  = w_binRe[4];  assign out4_i  = w_binIm[4];  assign out5_r  = w_binRe[5];  assign out5_i  = w_binIm[5];
    assign out6_r  = w_binRe[6];  assign out6_i  = w_binIm[6];  assign out7_r  = w_binRe[7];  assign out7_i  = w_binIm[7];
    assign out8_r  = w_binRe[8];  assign out8_i  = w_binIm[8];  assign out9_r  = w_binRe[9];  assign out9_i  = w_binIm[9];
    assign out10_r = w_binRe[10]; assign out10_i = w_binIm[10]; assign out11_r = w_binRe[11]; assign out11_i = w_binIm[11];
    assign out12_r = w_binRe[12]; assign out12_i = w_binIm[12]; assign out13_r = w_binRe[13]; assign out13_i = w_binIm[13];
    assign out14_r = w_binRe[14]; assign out14_i = w_binIm[14]; assign out15_r = w_binRe[15]; assign out15_i = w_binIm[15];
    assign out16_r = w_binRe[16]; assign out16_i = w_binIm[16]; assign out17_r = w_binRe[17]; assign out17_i = w_binIm[17];
    assign out18_r = w_binRe[18]; assign out18_i = w_binIm[18]; assign out19_r = w_binRe[19]; assign out19_i = w_binIm[19];
    assign out20_r = w_binRe[20]; assign out20_i = w_binIm[20]; assign out21_r = w_binRe[21]; assign out21_i = w_binIm[21];
    assign out22_r = w_binRe[22]; assign out22_i = w_binIm[22]; assign out23_r = w_binRe[23]; assign out23_i = w_binIm[23];
    assign out24_r = w_binRe[24]; assign out24_i = w_binIm[24]; assign out25_r = w_binRe[25]; assign out25_i = w_binIm[25];
    assign out26_r = w_binRe[26]; assign out26_i = w_binIm[26]; assign out27_r = w_binRe[27]; assign out27_i = w_binIm[27];
    assign out28_r = w_binRe[28]; assign out28_i = w_binIm[28]; assign out29_r = w_binRe[29]; assign out29_i = w_binIm[29];
    assign out30_r = w_binRe[30]; assign out30_i = w_binIm[30]; assign out31_r = w_binRe[31]; assign out31_i = w_binIm[31];

endmodule

// File: tb/tb_top.sv
// tb_top
// Scoreboard bench for the 32-point DFT: each frame of stimulus pushes its
// expected bins (from a double-precision DFT) and the frame result is popped
// and compared once the DUT publishes it, 33 edges after the LOAD.
module tb_top;

    localparam int  N  = 16;
    localparam real PI = 3.14159265358979323846;

    typedef struct {
        string tag;
        int    re;
        int    im;
        int    tol;
    } expect_t;

    logic clk2 = 1'b1;
    logic rst;
    logic signed [N-1:0] inR  [32];
    logic signed [N-1:0] outR [32];
    logic signed [N-1:0] outI [32];

    int      checks   = 0;
    int      failures = 0;
    expect_t sbQ[$];

    always #20 clk2 = ~clk2;

    top #(.N(N), .Q(0)) dut (
        .clk2(clk2), .rst(rst),
        .in0_r(inR[0]),   .in1_r(inR[1]),   .in2_r(inR[2]),   .in3_r(inR[3]),
        .in4_r(inR[4]),   .in5_r(inR[5]),   .in6_r(inR[6]),   .in7_r(inR[7]),
        .in8_r(inR[8]),   .in9_r(inR[9]),   .in10_r(inR[10]), .in11_r(inR[11]),
        .in12_r(inR[12]), .in13_r(inR[13]), .in14_r(inR[14]), .in15_r(inR[15]),
        .in16_r(inR[16]), .in17_r(inR[17]), .in18_r(inR[18]), .in19_r(inR[19]),
        .in20_r(inR[20]), .in21_r(inR[21]), .in22_r(inR[22]), .in23_r(inR[23]),
        .in24_r(inR[24]), .in25_r(inR[25]), .in26_r(inR[26]), .in27_r(inR[27]),
        .in28_r(inR[28]), .in29_r(inR[29]), .in30_r(inR[30]), .in31_r(inR[31]),
        .out0_r(outR[0]),   .out0_i(outI[0]),   .out1_r(outR[1]),   .out1_i(outI[1]),
        .out2_r(outR[2]),   .out2_i(outI[2]),   .out3_r(outR[3]),   .out3_i(outI[3]),
        .out4_r(outR[4]),   .out4_i(outI[4]),   .out5_r(outR[5]),   .out5_i(outI[5]),
        .out6_r(outR[6]),   .out6_i(outI[6]),   .out7_r(outR[7]),   .out7_i(outI[7]),
        .out8_r(outR[8]),   .out8_i(outI[8]),   .out9_r(outR[9]),   .out9_i(outI[9]),
        .out10_r(outR[10]), .out10_i(outI[10]), .out11_r(outR[11]), .out11_i(outI[11]),
        .out12_r(outR[12]), .out12_i(outI[12]), .out13_r(outR[13]), .out13_i(outI[13]),
        .out14_r(outR[14]), .out14_i(outI[14]), .out15_r(outR[15]), .out15_i(outI[15]),
        .out16_r(outR[16]), .out16_i(outI[16]), .out17_r(outR[17]), .out17_i(outI[17]),
        .out18_r(outR[18]), .out18_i(outI[18]), .out19_r(outR[19]), .out19_i(outI[19]),
        .out20_r(outR[20]), .out20_i(outI[20]), .out21_r(outR[21]), .out21_i(outI[21]),
        .out22_r(outR[22]), .out22_i(outI[22]), .out23_r(outR[23]), .out23_i(outI[23]),
        .out24_r(outR[24]), .out24_i(outI[24]), .out25_r(outR[25]), .out25_i(outI[25]),
        .out26_r(outR[26]), .out26_i(outI[26]), .out27_r(outR[27]), .out27_i(outI[27]),
        .out28_r(outR[28]), .out28_i(outI[28]), .out29_r(outR[29]), .out29_i(outI[29]),
        .out30_r(outR[30]), .out30_i(outI[30]), .out31_r(outR[31]), .out31_i(outI[31])
    );

    // Single comparison point: counts every check and reports any value
    // outside the allowed tolerance.
    task automatic checkOutput(input string tag, input int observed, input int expected, input int tol);
        int diff;
        checks++;
        diff = observed - expected;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d tol=%0d", tag, observed, expected, tol);
        end
    endtask

    // Round a real DFT value to the nearest integer and clamp to 16-bit range.
    function automatic int roundSat(input real v);
        real f;
        f = $floor(v + 0.5);
        if (f > 32767.0)  return 32767;
        if (f < -32768.0) return -32768;
        return $rtoi(f);
    endfunction

    // Drive one of the stimulus patterns and queue the expected bins for the
    // frame that will capture it. Bins 0 and 16 use only exact twiddles, so
    // they are checked exactly; the impulse is exact everywhere.
    task automatic applyStimulus(input string tag, input int pattern);
        expect_t e;
        real     re;
        real     im;
        real     ang;
        for (int n = 0; n < 32; n++) begin
            case (pattern)
                0:       inR[n] = 16'(2 + n / 4);
                1:       inR[n] = (n == 0) ? 16'sd5 : 16'sd0;
                2:       inR[n] = 16'sd1;
                default: inR[n] = 16'sd32767;
            endcase
        end
        for (int k = 0; k < 32; k++) begin
            re = 0.0;
            im = 0.0;
            for (int n = 0; n < 32; n++) begin
                ang = 2.0 * PI * real'((k * n) % 32) / 32.0;
                re  = re + real'(inR[n]) * $cos(ang);
                im  = im - real'(inR[n]) * $sin(ang);
            end
            e.tag = tag;
            e.re  = roundSat(re);
            e.im  = roundSat(im);
            e.tol = (pattern == 1 || k == 0 || k == 16) ? 0 : 1;
            sbQ.push_back(e);
        end
    endtask

    // Pop one frame of expectations and compare against all 64 outputs.
    task automatic compareFrame();
        expect_t e;
        checkOutput("sb_depth", (sbQ.size() >= 32) ? 1 : 0, 1, 0);
        if (sbQ.size() < 32) return;
        for (int k = 0; k < 32; k++) begin
            e = sbQ.pop_front();
            checkOutput($sformatf("%s_out%0d_r", e.tag, k), int'(outR[k]), e.re, e.tol);
            checkOutput($sformatf("%s_out%0d_i", e.tag, k), int'(outI[k]), e.im, e.tol);
        end
    endtask

    // All outputs must read zero while reset is applied.
    task automatic checkAllZero(input string tag);
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("%s_out%0d_r", tag, k), int'(outR[k]), 0, 0);
            checkOutput($sformatf("%s_out%0d_i", tag, k), int'(outI[k]), 0, 0);
        end
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk2);
        #1;
    endtask

    // Safety net so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, four back-to-back pattern frames, frame isolation,
    // and a reset that aborts a frame mid-accumulation.
    initial begin
        rst = 1'b1;
        for (int n = 0; n < 32; n++) inR[n] = '0;
        #10;
        checkAllZero("rst");

        applyStimulus("ramp", 0);
        #10;
        rst = 1'b0;
        waitEdges(33);
        compareFrame();
        checkOutput("ramp_out0_r_const", int'(outR[0]), 176, 0);

        applyStimulus("impulse", 1);
        waitEdges(33);
        compareFrame();

        applyStimulus("const", 2);
        waitEdges(33);
        compareFrame();
        checkOutput("const_out0_r_const", int'(outR[0]), 32, 0);

        applyStimulus("sat", 3);
        waitEdges(33);
        compareFrame();
        checkOutput("sat_out0_r_const", int'(outR[0]), 32767, 0);

        applyStimulus("iso_old", 0);
        waitEdges(11);
        checkOutput("hold_out0_r", int'(outR[0]), 32767, 0);
        applyStimulus("iso_new", 1);
        waitEdges(22);
        compareFrame();
        waitEdges(33);
        compareFrame();

        waitEdges(16);
        rst = 1'b1;
        #1;
        checkAllZero("midrst");
        applyStimulus("post_rst", 2);
        @(negedge clk2);
        rst = 1'b0;
        waitEdges(32);
        checkOutput("post_rst_early_out0_r", int'(outR[0]), 0, 0);
        waitEdges(1);
        compareFrame();

        checkOutput("sb_leftover", sbQ.size(), 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
